// File: rtl/ibex_fetch_align_buffer.sv
// ibex_fetch_align_buffer
//
// Circular-buffer fetch FIFO between the instruction prefetch bus and the ID
// stage. Word-aligned 32-bit fetch responses are stored in a DEPTH-entry ring.
// They are handed out as halfword-aligned instructions, compressed or
// uncompressed, each with its PC.
//
// Optional feature macro: IBEX_FETCH_ALIGN_BYPASS_EN
//   defined   - with an empty buffer the incoming word is forwarded
//               combinationally. It can also serve as the second word when
//               one word is stored.
//   undefined - no in_* -> out_* combinational path.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   clear_i, clear_addr_i  flush contents and load a new PC (bit 0 ignored)
//   busy_o                 thermometer fill of the top NUM_REQS slots
//   level_o                number of stored words
//   in_valid_i/rdata/err   fetch response
//   out_valid_o/ready_i    instruction handshake towards ID
//   out_addr_o             instruction PC
//   out_rdata_o            instruction (upper half don't-care if compressed)
//   out_err_o              fetch error on this instruction
//   out_err_plus2_o        error only in the second half of an unaligned instr
module ibex_fetch_align_buffer #(
    parameter int unsigned NUM_REQS     = 2,
    parameter int unsigned DEPTH        = NUM_REQS + 1,
    parameter bit          ALIGNED_ONLY = 1'b0,
    parameter bit          ResetAll     = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic [31:0]                clear_addr_i,
    output logic [NUM_REQS-1:0]        busy_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    input  logic                       in_valid_i,
    input  logic [31:0]                in_rdata_i,
    input  logic                       in_err_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                out_addr_o,
    output logic [31:0]                out_rdata_o,
    output logic                       out_err_o,
    output logic                       out_err_plus2_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (DEPTH < NUM_REQS + 1) begin : g_depth_check
        $error("ibex_fetch_align_buffer: DEPTH must be at least NUM_REQS+1");
    end

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [DEPTH-1:0][31:0] rdata_q;
    logic [DEPTH-1:0]       err_q;
    logic [PW-1:0]          rd_ptr_q, wr_ptr_q, rd_ptr_nxt1;
    logic [CW-1:0]          count_q;
    logic [31:0]            pc_q;

    logic        byp_valid;
    logic        cnt_zero, cnt_one, cnt_ge2, full;
    logic        head_byp, head_valid, head_err;
    logic [31:0] head_rdata;
    logic        sec_byp, sec_valid, sec_err;
    logic [15:0] sec_lo;
    logic        off, compressed;
    logic [1:0]  half_lsb;
    logic        pop, consume, pop_store, byp_taken, push_req, push;
    logic        unused_clear_addr0;

`ifdef IBEX_FETCH_ALIGN_BYPASS_EN
    assign byp_valid = in_valid_i;
`else
    assign byp_valid = 1'b0;
`endif

    assign unused_clear_addr0 = clear_addr_i[0];

    assign cnt_zero    = (count_q == '0);
    assign cnt_one     = (count_q == CW'(1));
    assign cnt_ge2     = (count_q >= CW'(2));
    assign full        = (count_q == CW'(DEPTH));
    assign rd_ptr_nxt1 = ptr_inc(rd_ptr_q);

    // Head word: oldest stored word, or the incoming word when empty.
    // Without a bypass the stored slot is still selected so that a reset
    // storage reads as zero.
    assign head_byp   = cnt_zero & byp_valid;
    assign head_valid = ~cnt_zero | head_byp;
    assign head_rdata = head_byp ? in_rdata_i : rdata_q[rd_ptr_q];
    assign head_err   = head_valid & (head_byp ? in_err_i : err_q[rd_ptr_q]);

    // Second word: only its lower half is ever needed.
    assign sec_byp   = cnt_one & byp_valid;
    assign sec_valid = cnt_ge2 | sec_byp;
    assign sec_lo    = sec_byp ? in_rdata_i[15:0] : rdata_q[rd_ptr_nxt1][15:0];
    assign sec_err   = sec_valid & (sec_byp ? in_err_i : err_q[rd_ptr_nxt1]);

    assign off        = ALIGNED_ONLY ? 1'b0 : pc_q[1];
    assign half_lsb   = off ? head_rdata[17:16] : head_rdata[1:0];
    assign compressed = (half_lsb != 2'b11) & ~head_err;

    // An erroring head is released on its own so the error reaches ID even
    // if the second word never arrives.
    assign out_valid_o     = head_valid & (~off | compressed | head_err | sec_valid);
    assign out_rdata_o     = off ? {sec_lo, head_rdata[31:16]} : head_rdata;
    assign out_err_o       = head_err | (off & ~compressed & sec_err);
    assign out_err_plus2_o = off & ~compressed & ~head_err & sec_err;
    assign out_addr_o      = pc_q;

    // A compressed instruction in the lower half leaves the word in place
    // for the upper half; every other pop finishes the head word.
    assign pop       = out_valid_o & out_ready_i;
    assign consume   = pop & (off | ~compressed | ALIGNED_ONLY);
    assign pop_store = consume & ~cnt_zero;
    assign byp_taken = consume & cnt_zero;

    // A word forwarded and consumed in the same cycle never enters storage.
    assign push_req = in_valid_i & ~clear_i & ~byp_taken;
    assign push     = push_req & ~(full & ~pop_store);

    assign level_o = count_q;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_busy
        assign busy_o[i] = (count_q >= CW'(DEPTH - NUM_REQS + 1 + i));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            pc_q     <= '0;
        end else if (clear_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            pc_q     <= {clear_addr_i[31:1], 1'b0};
        end else begin
            if (push)      wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_store) rd_ptr_q <= rd_ptr_nxt1;
            count_q <= count_q + CW'(push) - CW'(pop_store);
            if (pop)       pc_q <= pc_q + (compressed ? 32'd2 : 32'd4);
        end
    end

    if (ResetAll) begin : g_store_rst
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rdata_q <= '0;
                err_q   <= '0;
            end else if (push) begin
                rdata_q[wr_ptr_q] <= in_rdata_i;
                err_q[wr_ptr_q]   <= in_err_i;
            end
        end
    end else begin : g_store
        // Stale data is harmless: count_q gates every read.
        always_ff @(posedge clk_i) begin
            if (push) begin
                rdata_q[wr_ptr_q] <= in_rdata_i;
                err_q[wr_ptr_q]   <= in_err_i;
            end
        end
    end

    // The upstream request limit must stop a response arriving into a full
    // buffer that is not draining.
    full_push_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(in_valid_i && !clear_i && full && !pop_store));

endmodule

// File: tb/tb_ibex_fetch_align_buffer.sv
module tb_ibex_fetch_align_buffer;

    localparam int NUM_REQS = 2;
    localparam int DEPTH    = 3;
    localparam int LW       = $clog2(DEPTH + 1);

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    logic                clear_i = 1'b0;
    logic [31:0]         clear_addr_i = '0;
    logic [NUM_REQS-1:0] busy_o;
    logic [LW-1:0]       level_o;
    logic                in_valid_i = 1'b0;
    logic [31:0]         in_rdata_i = '0;
    logic                in_err_i = 1'b0;
    logic                out_valid_o;
    logic                out_ready_i = 1'b0;
    logic [31:0]         out_addr_o;
    logic [31:0]         out_rdata_o;
    logic                out_err_o;
    logic                out_err_plus2_o;

    ibex_fetch_align_buffer #(
        .NUM_REQS(NUM_REQS),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .clear_addr_i   (clear_addr_i),
        .busy_o         (busy_o),
        .level_o        (level_o),
        .in_valid_i     (in_valid_i),
        .in_rdata_i     (in_rdata_i),
        .in_err_i       (in_err_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_addr_o     (out_addr_o),
        .out_rdata_o    (out_rdata_o),
        .out_err_o      (out_err_o),
        .out_err_plus2_o(out_err_plus2_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        c16;   // only the low halfword is meaningful
        logic        err;
        logic        ep2;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total  = 0;
    int   passed = 0;

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_clear(input logic [31:0] a);
        clear_i      = 1'b1;
        clear_addr_i = a;
        tick();
        clear_i = 1'b0;
        sb.delete();
    endtask

    // Push one word with out_ready_i low; expectation queued alongside.
    task automatic push_word(input logic [31:0] d, input logic er);
        in_valid_i = 1'b1;
        in_rdata_i = d;
        in_err_i   = er;
        tick();
        in_valid_i = 1'b0;
        in_err_i   = 1'b0;
    endtask

    function automatic logic [NUM_REQS-1:0] busy_model(input int lvl);
        logic [NUM_REQS-1:0] b;
        for (int i = 0; i < NUM_REQS; i++) b[i] = (lvl >= DEPTH - NUM_REQS + 1 + i);
        return b;
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid_o); else passed++;
        total++; if (out_err_o !== 1'b0) $display("FAIL reset_err got %b want 0", out_err_o); else passed++;
        total++; if (out_err_plus2_o !== 1'b0) $display("FAIL reset_ep2 got %b want 0", out_err_plus2_o); else passed++;
        total++; if (busy_o !== '0) $display("FAIL reset_busy got %b want 0", busy_o); else passed++;
        total++; if (level_o !== '0) $display("FAIL reset_level got %0d want 0", level_o); else passed++;
        total++; if (out_addr_o !== 32'h0) $display("FAIL reset_addr got %h want 0", out_addr_o); else passed++;
    endtask

    task automatic test_basic();
        do_clear(32'h100);
        total++; if (out_addr_o !== 32'h100) $display("FAIL basic_clear_addr got %h want 00000100", out_addr_o); else passed++;
        in_valid_i = 1'b1;
        in_rdata_i = 32'h00A3_0513;
        sb.push_back('{32'h100, 32'h00A3_0513, 1'b0, 1'b0, 1'b0});
        #1;
`ifdef IBEX_FETCH_ALIGN_BYPASS_EN
        total++; if (out_valid_o !== 1'b1) $display("FAIL basic_bypass_valid got %b want 1", out_valid_o); else passed++;
`else
        total++; if (out_valid_o !== 1'b0) $display("FAIL basic_nobypass_valid got %b want 0", out_valid_o); else passed++;
`endif
        tick();
        in_valid_i = 1'b0;
        #1;
        total++; if (level_o !== LW'(1)) $display("FAIL basic_level got %0d want 1", level_o); else passed++;
        out_ready_i = 1'b1;
        #1;
        e = sb.pop_front();
        total++;
        if (out_valid_o !== 1'b1 || out_addr_o !== e.addr || out_rdata_o !== e.data ||
            out_err_o !== e.err || out_err_plus2_o !== e.ep2)
            $display("FAIL basic_pop got v=%b a=%h d=%h e=%b p=%b want a=%h d=%h e=%b p=%b",
                     out_valid_o, out_addr_o, out_rdata_o, out_err_o, out_err_plus2_o, e.addr, e.data, e.err, e.ep2);
        else passed++;
        tick();
        out_ready_i = 1'b0;
        #1;
        total++; if (out_addr_o !== 32'h104) $display("FAIL basic_pc_after got %h want 00000104", out_addr_o); else passed++;
        total++; if (level_o !== '0 || out_valid_o !== 1'b0) $display("FAIL basic_empty got l=%0d v=%b want 0 0", level_o, out_valid_o); else passed++;
    endtask

    task automatic test_unaligned();
        do_clear(32'h102);
        push_word(32'h1234_4501, 1'b0);
        push_word(32'h0000_5678, 1'b0);
        sb.push_back('{32'h102, 32'h0000_1234, 1'b1, 1'b0, 1'b0});
        sb.push_back('{32'h104, 32'h0000_5678, 1'b1, 1'b0, 1'b0});
        total++; if (level_o !== LW'(2)) $display("FAIL unal_level2 got %0d want 2", level_o); else passed++;
        out_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            e = sb.pop_front();
            total++;
            if (out_valid_o !== 1'b1 || out_addr_o !== e.addr || out_rdata_o[15:0] !== e.data[15:0] || out_err_o !== e.err)
                $display("FAIL unal_pop%0d got v=%b a=%h d=%h e=%b want a=%h d=%h", k, out_valid_o, out_addr_o,
                         out_rdata_o[15:0], out_err_o, e.addr, e.data[15:0]);
            else passed++;
            tick();
        end
        out_ready_i = 1'b0;
        #1;
        total++; if (out_addr_o !== 32'h106) $display("FAIL unal_pc got %h want 00000106", out_addr_o); else passed++;
        total++; if (level_o !== LW'(1)) $display("FAIL unal_level got %0d want 1", level_o); else passed++;
    endtask

    task automatic test_err_plus2();
        do_clear(32'h202);
        push_word(32'h0013_0000, 1'b0);
        #1;
        total++; if (out_valid_o !== 1'b0) $display("FAIL err_wait_second got %b want 0", out_valid_o); else passed++;
        push_word(32'h0000_0001, 1'b1);
        #1;
        total++; if (out_err_o !== 1'b1) $display("FAIL err_out got %b want 1", out_err_o); else passed++;
        total++; if (out_err_plus2_o !== 1'b1) $display("FAIL err_plus2 got %b want 1", out_err_plus2_o); else passed++;
        sb.push_back('{32'h202, 32'h0001_0013, 1'b0, 1'b1, 1'b1});
        out_ready_i = 1'b1;
        #1;
        e = sb.pop_front();
        total++;
        if (out_valid_o !== 1'b1 || out_addr_o !== e.addr || out_rdata_o !== e.data ||
            out_err_o !== e.err || out_err_plus2_o !== e.ep2)
            $display("FAIL err_pop got v=%b a=%h d=%h e=%b p=%b want a=%h d=%h e=%b p=%b",
                     out_valid_o, out_addr_o, out_rdata_o, out_err_o, out_err_plus2_o, e.addr, e.data, e.err, e.ep2);
        else passed++;
        tick();
        out_ready_i = 1'b0;
        #1;
        total++; if (out_addr_o !== 32'h206) $display("FAIL err_pc got %h want 00000206", out_addr_o); else passed++;
        // Erroring head: released alone, error not attributed to the upper half.
        do_clear(32'h202);
        push_word(32'h0013_0000, 1'b1);
        #1;
        total++; if (out_valid_o !== 1'b1 || out_err_o !== 1'b1) $display("FAIL err_head_alone got v=%b e=%b want 1 1", out_valid_o, out_err_o); else passed++;
        push_word(32'h0000_0001, 1'b1);
        #1;
        total++; if (out_err_o !== 1'b1) $display("FAIL err_head_out got %b want 1", out_err_o); else passed++;
        total++; if (out_err_plus2_o !== 1'b0) $display("FAIL err_head_plus2 got %b want 0", out_err_plus2_o); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        pc = 32'h0;
        do_clear(32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            push_word(32'hC0DE_0003 + 32'(i << 4), 1'b0);
            sb.push_back('{pc, 32'hC0DE_0003 + 32'(i << 4), 1'b0, 1'b0, 1'b0});
            pc += 4;
            #1;
            total++;
            if (level_o !== LW'(i + 1) || busy_o !== busy_model(i + 1))
                $display("FAIL fill%0d got l=%0d b=%b want l=%0d b=%b", i, level_o, busy_o, i + 1, busy_model(i + 1));
            else passed++;
        end
        total++; if (busy_o !== '1) $display("FAIL full_busy got %b want all ones", busy_o); else passed++;
        out_ready_i = 1'b1;
        for (int k = 0; k < 4 * DEPTH; k++) begin
            if (k < 3 * DEPTH) begin
                in_valid_i = 1'b1;
                in_rdata_i = 32'hC0DE_0003 + 32'((DEPTH + k) << 4);
                sb.push_back('{pc, in_rdata_i, 1'b0, 1'b0, 1'b0});
                pc += 4;
            end else begin
                in_valid_i = 1'b0;
            end
            #1;
            e = sb.pop_front();
            total++;
            if (out_valid_o !== 1'b1 || out_addr_o !== e.addr || out_rdata_o !== e.data)
                $display("FAIL stream%0d got v=%b a=%h d=%h want a=%h d=%h", k, out_valid_o, out_addr_o, out_rdata_o, e.addr, e.data);
            else passed++;
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #1;
        total++; if (level_o !== '0 || out_valid_o !== 1'b0) $display("FAIL stream_empty got l=%0d v=%b want 0 0", level_o, out_valid_o); else passed++;
        total++; if (out_addr_o !== pc) $display("FAIL stream_pc got %h want %h", out_addr_o, pc); else passed++;
    endtask

    task automatic test_clear();
        do_clear(32'h0);
        push_word(32'h1111_0003, 1'b0);
        push_word(32'h2222_0003, 1'b0);
        total++; if (level_o !== LW'(2)) $display("FAIL clr_level2 got %0d want 2", level_o); else passed++;
        clear_i      = 1'b1;
        clear_addr_i = 32'h340;
        in_valid_i   = 1'b1;
        in_rdata_i   = 32'hDEAD_0003;
        out_ready_i  = 1'b1;
        tick();
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        sb.delete();
        #1;
        total++; if (level_o !== '0) $display("FAIL clr_level got %0d want 0", level_o); else passed++;
        total++; if (out_addr_o !== 32'h340) $display("FAIL clr_pc got %h want 00000340", out_addr_o); else passed++;
        total++; if (out_valid_o !== 1'b0) $display("FAIL clr_valid got %b want 0", out_valid_o); else passed++;
        push_word(32'h00B0_0093, 1'b0);
        sb.push_back('{32'h340, 32'h00B0_0093, 1'b0, 1'b0, 1'b0});
        out_ready_i = 1'b1;
        #1;
        e = sb.pop_front();
        total++;
        if (out_valid_o !== 1'b1 || out_addr_o !== e.addr || out_rdata_o !== e.data)
            $display("FAIL clr_next_pop got v=%b a=%h d=%h want a=%h d=%h", out_valid_o, out_addr_o, out_rdata_o, e.addr, e.data);
        else passed++;
        tick();
        out_ready_i = 1'b0;
        #1;
        total++; if (level_o !== '0 || out_addr_o !== 32'h344) $display("FAIL clr_after got l=%0d a=%h want 0 00000344", level_o, out_addr_o); else passed++;
    endtask

    task automatic test_reset_mid();
        do_clear(32'h500);
        push_word(32'hAAAA_0003, 1'b0);
        push_word(32'hBBBB_0003, 1'b1);
        push_word(32'hCCCC_0003, 1'b0);
        total++; if (level_o !== LW'(3)) $display("FAIL rstmid_level3 got %0d want 3", level_o); else passed++;
        test_reset();
        sb.delete();
        test_basic();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_unaligned();
        test_err_plus2();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
